// File: rtl/frontend_fetch_decode_rename.sv
// In-order RV32 front end: fetches from a flat ROM bus, decodes fields/controls,
// and renames through a RAT, circular free list and ready/value register file.
module frontend_fetch_decode_rename #(
  parameter int ROM_WORDS = 256,
  parameter int PHYS_REGS = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [32*ROM_WORDS-1:0]  instr_rom,
  input  logic [31:0]              rom_size,
  input  logic                     wakeup_active,
  input  logic [$clog2(PHYS_REGS)-1:0] wakeup_tag,
  input  logic [31:0]              wakeup_value,
  input  logic [$clog2(PHYS_REGS)-1:0] freed_tag_1,
  input  logic [$clog2(PHYS_REGS)-1:0] freed_tag_2,
  output logic                     fetch_complete,
  output logic                     inst_valid,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [2:0]               func3,
  output logic [31:0]              imm,
  output logic                     LoadStore,
  output logic                     ALUSrc,
  output logic                     RegWrite,
  output logic                     BMS,
  output logic [3:0]               ALUControl,
  output logic [$clog2(PHYS_REGS)-1:0] physical_rd,
  output logic [$clog2(PHYS_REGS)-1:0] physical_rs1,
  output logic [$clog2(PHYS_REGS)-1:0] physical_rs2,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_value,
  output logic [31:0]              rs2_value,
  output logic                     rename_stall
);
  localparam int TW = $clog2(PHYS_REGS);
  localparam int AW = $clog2(ROM_WORDS);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [31:0] pc, ir, rom_word;
  logic [TW-1:0] rat [32];
  logic [PHYS_REGS-1:0] ready;
  logic [31:0] prf [PHYS_REGS];
  logic [TW-1:0] fl [PHYS_REGS];
  logic [TW-1:0] fl_head, fl_tail;
  logic [TW:0] fl_count;
  logic alloc_need, alloc, push1, push2;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic sub_ok);
    case (f3)
      3'b000:  alu_sel = (alt && sub_ok) ? 4'd1 : 4'd0;
      3'b100:  alu_sel = 4'd2;
      3'b110:  alu_sel = 4'd3;
      3'b111:  alu_sel = 4'd4;
      3'b001:  alu_sel = 4'd5;
      3'b101:  alu_sel = alt ? 4'd7 : 4'd6;
      default: alu_sel = 4'd0;
    endcase
  endfunction

  // Words past the end of the bus read as zero rather than aliasing.
  always_comb begin
    rom_word = '0;
    if (pc[31:2] < 30'(ROM_WORDS)) rom_word = instr_rom[{pc[AW+1:2], 5'b0} +: 32];
  end

  assign fetch_complete = pc >= rom_size;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign func3  = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  always_comb begin
    imm = '0; ALUControl = 4'd0;
    LoadStore = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b0; BMS = 1'b0;
    case (opcode)
      OP_R: begin
        RegWrite = 1'b1; ALUControl = alu_sel(func3, ir[30], 1'b1);
      end
      OP_I: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; imm = {{20{ir[31]}}, ir[31:20]};
        ALUControl = alu_sel(func3, ir[30], 1'b0);
      end
      OP_LD: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; LoadStore = 1'b1; BMS = (func3 == 3'b000);
        imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_ST: begin
        ALUSrc = 1'b1; LoadStore = 1'b1; BMS = (func3 == 3'b000);
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_LUI: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; imm = {ir[31:12], 12'h000}; ALUControl = 4'd8;
      end
      default: ;
    endcase
  end

  assign alloc_need   = inst_valid && RegWrite && (rd != 5'd0);
  assign rename_stall = alloc_need && (fl_count == '0);
  assign alloc        = alloc_need && !rename_stall;
  assign physical_rd  = alloc ? fl[fl_head] : '0;
  assign physical_rs1 = rat[rs1];
  assign physical_rs2 = rat[rs2];
  assign push1 = freed_tag_1 != '0;
  assign push2 = freed_tag_2 != '0;

  // Same-cycle writeback bypass; tag 0 is hardwired ready/zero.
  always_comb begin
    rs1_ready = ready[physical_rs1] || (wakeup_active && wakeup_tag == physical_rs1);
    rs2_ready = ready[physical_rs2] || (wakeup_active && wakeup_tag == physical_rs2);
    rs1_value = prf[physical_rs1];
    rs2_value = prf[physical_rs2];
    if (wakeup_active && wakeup_tag == physical_rs1 && physical_rs1 != '0) rs1_value = wakeup_value;
    if (wakeup_active && wakeup_tag == physical_rs2 && physical_rs2 != '0) rs2_value = wakeup_value;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0; ir <= '0; inst_valid <= 1'b0;
      for (int i = 0; i < 32; i++) rat[i] <= TW'(i);
      ready <= '1;
      for (int i = 0; i < PHYS_REGS; i++) begin
        prf[i] <= '0;
        fl[i]  <= (i < PHYS_REGS - 32) ? TW'(i + 32) : '0;
      end
      fl_head  <= '0;
      fl_tail  <= TW'(PHYS_REGS - 32);
      fl_count <= (TW+1)'(PHYS_REGS - 32);
    end else begin
      if (!rename_stall) begin
        if (fetch_complete) begin
          ir <= '0; inst_valid <= 1'b0;
        end else begin
          ir <= rom_word; pc <= pc + 32'd4; inst_valid <= 1'b1;
        end
      end
      if (wakeup_active && wakeup_tag != '0) begin
        ready[wakeup_tag] <= 1'b1;
        prf[wakeup_tag]   <= wakeup_value;
      end
      // A fresh allocation wins over any stale wakeup of the same tag.
      if (alloc) begin
        rat[rd]            <= fl[fl_head];
        ready[fl[fl_head]] <= 1'b0;
        fl_head            <= fl_head + TW'(1);
      end
      if (push1) fl[fl_tail] <= freed_tag_1;
      if (push2) fl[push1 ? fl_tail + TW'(1) : fl_tail] <= freed_tag_2;
      fl_tail  <= fl_tail + TW'(push1) + TW'(push2);
      fl_count <= fl_count + (TW+1)'(push1) + (TW+1)'(push2) - (TW+1)'(alloc);
    end
  end
endmodule

// File: tb/tb_frontend_fetch_decode_rename.sv
// Random-program bench for the front end against a queue/array rename model.
module tb_frontend_fetch_decode_rename;
  localparam int ROM_WORDS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [32*ROM_WORDS-1:0] instr_rom;
  logic [31:0] rom_size;
  logic wakeup_active;
  logic [5:0] wakeup_tag, freed_tag_1, freed_tag_2;
  logic [31:0] wakeup_value;
  logic fetch_complete, inst_valid, LoadStore, ALUSrc, RegWrite, BMS;
  logic rs1_ready, rs2_ready, rename_stall;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] func3;
  logic [31:0] imm, rs1_value, rs2_value;
  logic [3:0] ALUControl;
  logic [5:0] physical_rd, physical_rs1, physical_rs2;

  frontend_fetch_decode_rename #(.ROM_WORDS(ROM_WORDS), .PHYS_REGS(64)) dut (
    .clk(clk), .reset(reset), .instr_rom(instr_rom), .rom_size(rom_size),
    .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
    .freed_tag_1(freed_tag_1), .freed_tag_2(freed_tag_2),
    .fetch_complete(fetch_complete), .inst_valid(inst_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .imm(imm),
    .LoadStore(LoadStore), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .BMS(BMS),
    .ALUControl(ALUControl), .physical_rd(physical_rd), .physical_rs1(physical_rs1),
    .physical_rs2(physical_rs2), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rename_stall(rename_stall)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Instruction word plus the controls the generator intended it to carry.
  typedef struct {
    logic [31:0] w;
    logic [31:0] imm;
    logic [3:0]  aluc;
    bit ls, src, rw, bms;
  } ins_t;

  ins_t prog [ROM_WORDS];
  int m_pc, m_idx;
  bit m_vld;
  int rat [32];
  bit rdy [64];
  logic [31:0] val [64];
  int fl [$];
  int pool [$];

  function automatic ins_t mk(input logic [31:0] w, input logic [31:0] i, input int aluc,
                              input bit ls, input bit src, input bit rw, input bit bms);
    ins_t x;
    x.w = w; x.imm = i; x.aluc = 4'(aluc); x.ls = ls; x.src = src; x.rw = rw; x.bms = bms;
    return x;
  endfunction

  // Operation n: 0 ADD/SUB, 1 XOR, 2 OR, 3 AND, 4 SLL, 5 SRL/SRA.
  function automatic logic [2:0] op_f3(input int n);
    case (n)
      0: return 3'b000; 1: return 3'b100; 2: return 3'b110;
      3: return 3'b111; 4: return 3'b001; default: return 3'b101;
    endcase
  endfunction

  function automatic int op_alu(input int n, input bit alt);
    case (n)
      0: return alt ? 1 : 0; 1: return 2; 2: return 3;
      3: return 4; 4: return 5; default: return alt ? 7 : 6;
    endcase
  endfunction

  function automatic ins_t gen();
    ins_t x = mk(0, 0, 0, 0, 0, 0, 0);
    int k = $urandom_range(0, 5);
    int n = $urandom_range(0, 5);
    logic [4:0] d = 5'($urandom_range(0, 7));
    logic [4:0] s1 = 5'($urandom_range(0, 7));
    logic [4:0] s2 = 5'($urandom_range(0, 7));
    logic [11:0] i12 = 12'($urandom);
    logic [31:0] r = $urandom;
    bit alt = r[0];
    bit a;
    logic [2:0] f3 = op_f3(n);
    case (k)
      0: begin
        if (n == 4) i12[11:5] = 7'h00;
        if (n == 5) i12[11:5] = alt ? 7'h20 : 7'h00;
        x = mk({i12, s1, f3, d, 7'b0010011}, 32'($signed(i12)), op_alu(n, alt && n == 5), 0, 1, 1, 0);
      end
      1: begin
        a = alt && (n == 0 || n == 5);
        x = mk({a ? 7'h20 : 7'h00, s2, s1, f3, d, 7'b0110011}, 0, op_alu(n, a), 0, 0, 1, 0);
      end
      2: begin
        f3 = r[1] ? 3'b000 : 3'b010;
        x = mk({i12, s1, f3, d, 7'b0000011}, 32'($signed(i12)), 0, 1, 1, 1, f3 == 3'b000);
      end
      3: begin
        f3 = r[1] ? 3'b000 : 3'b010;
        x = mk({i12[11:5], s2, s1, f3, i12[4:0], 7'b0100011}, 32'($signed(i12)), 0, 1, 1, 0, f3 == 3'b000);
      end
      4: x = mk({r[31:12], d, 7'b0110111}, {r[31:12], 12'h000}, 8, 0, 1, 1, 0);
      default: x = mk({r[31:7], 7'b1100011}, 0, 0, 0, 0, 0, 0);
    endcase
    return x;
  endfunction

  task automatic clear_rom();
    for (int k = 0; k < ROM_WORDS; k++) prog[k] = mk(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_rom();
    for (int k = 0; k < ROM_WORDS; k++) instr_rom[32*k +: 32] = prog[k].w;
  endtask

  task automatic m_reset();
    m_pc = 0; m_idx = 0; m_vld = 0;
    for (int i = 0; i < 32; i++) rat[i] = i;
    for (int i = 0; i < 64; i++) begin rdy[i] = 1; val[i] = 0; end
    fl = {}; pool = {};
    for (int t = 32; t < 64; t++) fl.push_back(t);
  endtask

  function automatic bit m_need();
    ins_t e = prog[m_idx];
    return m_vld && e.rw && (e.w[11:7] != 5'd0);
  endfunction

  task automatic check_outputs(input bit wk, input int wt, input logic [31:0] wv);
    ins_t e = mk(0, 0, 0, 0, 0, 0, 0);
    logic [31:0] w;
    bit need, stall;
    int t1, t2;
    if (m_vld) e = prog[m_idx];
    w = e.w;
    need = m_need();
    stall = need && (fl.size() == 0);
    chk("fetch_complete", fetch_complete, 32'(m_pc) >= rom_size);
    chk("inst_valid", inst_valid, m_vld);
    chk("opcode", opcode, w[6:0]);
    chk("rd", rd, w[11:7]);
    chk("func3", func3, w[14:12]);
    chk("rs1", rs1, w[19:15]);
    chk("rs2", rs2, w[24:20]);
    chk("imm", imm, e.imm);
    chk("ALUControl", ALUControl, e.aluc);
    chk("LoadStore", LoadStore, e.ls);
    chk("ALUSrc", ALUSrc, e.src);
    chk("RegWrite", RegWrite, e.rw);
    chk("BMS", BMS, e.bms);
    chk("rename_stall", rename_stall, stall);
    if (!stall) chk("physical_rd", physical_rd, need ? fl[0] : 0);
    t1 = rat[w[19:15]];
    t2 = rat[w[24:20]];
    chk("physical_rs1", physical_rs1, t1);
    chk("physical_rs2", physical_rs2, t2);
    chk("rs1_ready", rs1_ready, rdy[t1] || (wk && wt == t1));
    chk("rs2_ready", rs2_ready, rdy[t2] || (wk && wt == t2));
    chk("rs1_value", rs1_value, (wk && wt == t1 && t1 != 0) ? wv : val[t1]);
    chk("rs2_value", rs2_value, (wk && wt == t2 && t2 != 0) ? wv : val[t2]);
  endtask

  task automatic m_step(input bit wk, input int wt, input logic [31:0] wv, input int f1, input int f2);
    bit need = m_need();
    bit stall = need && (fl.size() == 0);
    int t, d;
    if (wk && wt != 0) begin rdy[wt] = 1; val[wt] = wv; end
    if (need && !stall) begin
      d = int'(prog[m_idx].w[11:7]);
      t = fl.pop_front();
      if (rat[d] != 0) pool.push_back(rat[d]);
      rat[d] = t;
      rdy[t] = 0;
    end
    if (f1 != 0) fl.push_back(f1);
    if (f2 != 0) fl.push_back(f2);
    if (!stall) begin
      if (32'(m_pc) >= rom_size) m_vld = 0;
      else begin m_idx = m_pc / 4; m_vld = 1; m_pc += 4; end
    end
  endtask

  task automatic cycle(input bit wk, input int wt, input logic [31:0] wv, input int f1, input int f2);
    @(negedge clk);
    wakeup_active = wk; wakeup_tag = 6'(wt); wakeup_value = wv;
    freed_tag_1 = 6'(f1); freed_tag_2 = 6'(f2);
    #1 check_outputs(wk, wt, wv);
    m_step(wk, wt, wv, f1, f2);
  endtask

  // Holds reset across one edge, releases it and checks the reset state.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    wakeup_active = 0; wakeup_tag = 0; wakeup_value = 0; freed_tag_1 = 0; freed_tag_2 = 0;
    @(negedge clk);
    #1 reset = 1'b1;
    m_reset();
    check_outputs(0, 0, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_prd", physical_rd, 0);
    m_step(0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input int free_pct);
    bit wk = 0;
    int wt = 0, f1 = 0, f2 = 0, idx;
    int cand [$];
    if ($urandom_range(0, 99) < 50) begin
      for (int t = 1; t < 64; t++) if (!rdy[t]) cand.push_back(t);
      if (cand.size() > 0) begin wk = 1; wt = cand[$urandom_range(0, cand.size() - 1)]; end
      else if ($urandom_range(0, 3) == 0) wk = 1;
    end
    if (pool.size() > 0 && $urandom_range(0, 99) < free_pct) begin
      idx = $urandom_range(0, pool.size() - 1); f1 = pool[idx]; pool.delete(idx);
    end
    if (pool.size() > 0 && $urandom_range(0, 99) < free_pct / 2) begin
      idx = $urandom_range(0, pool.size() - 1); f2 = pool[idx]; pool.delete(idx);
    end
    cycle(wk, wt, $urandom, f1, f2);
  endtask

  initial begin
    reset = 1'b0; instr_rom = '0; rom_size = 0;
    wakeup_active = 0; wakeup_tag = 0; wakeup_value = 0; freed_tag_1 = 0; freed_tag_2 = 0;
    m_reset();

    // Empty program: complete straight out of reset.
    clear_rom(); load_rom(); rom_size = 0;
    do_reset();
    repeat (3) cycle(0, 0, 0, 0, 0);
    chk("empty_complete", fetch_complete, 1);

    // Single ADDI then done.
    clear_rom();
    prog[0] = mk(32'h00700293, 7, 0, 0, 1, 1, 0);
    load_rom(); rom_size = 4;
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk("t1_valid", inst_valid, 1); chk("t1_rd", rd, 5); chk("t1_imm", imm, 7);
    chk("t1_prd", physical_rd, 32); chk("t1_prs1", physical_rs1, 0); chk("t1_rdy1", rs1_ready, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t1_done", fetch_complete, 1); chk("t1_idle", inst_valid, 0);

    // Dependent ADD with same-cycle wakeup, byte store, LUI, negative immediate.
    clear_rom();
    prog[0] = mk(32'h00700293, 7, 0, 0, 1, 1, 0);
    prog[1] = mk(32'h00528333, 0, 0, 0, 0, 1, 0);
    prog[2] = mk(32'h005081A3, 3, 0, 1, 1, 0, 1);
    prog[3] = mk(32'h123450B7, 32'h12345000, 8, 0, 1, 1, 0);
    prog[4] = mk(32'hFFF00393, 32'hFFFFFFFF, 0, 0, 1, 1, 0);
    load_rom(); rom_size = 20;
    do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32, 7, 0, 0);
    chk("t2_prs1", physical_rs1, 32); chk("t2_prs2", physical_rs2, 32);
    chk("t2_prd", physical_rd, 33); chk("t2_rdy1", rs1_ready, 1); chk("t2_val1", rs1_value, 7);
    cycle(0, 0, 0, 0, 0);
    chk("t2_sb_bms", BMS, 1); chk("t2_sb_prd", physical_rd, 0); chk("t2_sb_imm", imm, 3);
    cycle(0, 0, 0, 0, 0);
    chk("t2_lui_imm", imm, 32'h12345000); chk("t2_lui_prd", physical_rd, 34);
    cycle(0, 0, 0, 0, 0);
    chk("t2_neg_imm", imm, 32'hFFFFFFFF);
    // Tag 0 wakeup must not disturb x0.
    cycle(1, 0, 32'hDEADBEEF, 0, 0);
    chk("t2_x0_val", rs1_value, 0);

    // Exhaust the free list, then release one tag.
    clear_rom();
    for (int k = 0; k < 34; k++) prog[k] = mk(32'h00100093, 1, 0, 0, 1, 1, 0);
    load_rom(); rom_size = 34 * 4;
    do_reset();
    repeat (32) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t3_stall", rename_stall, 1); chk("t3_not_done", fetch_complete, 0);
    cycle(0, 0, 0, 32, 0);
    chk("t3_still_stall", rename_stall, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t3_unstall", rename_stall, 0); chk("t3_prd", physical_rd, 32);

    // Random programs with random wakeups/frees and occasional mid-stream reset.
    for (int run = 0; run < 8; run++) begin
      int n = $urandom_range(20, 80);
      int len = n + 40;
      int rst_at = (run % 2 == 1) ? $urandom_range(5, n) : -1;
      int free_pct = (run % 3 == 0) ? 10 : 60;
      clear_rom();
      for (int k = 0; k < n; k++) prog[k] = gen();
      load_rom();
      rom_size = 32'(n * 4 - (($urandom_range(0, 1) == 1) ? 2 : 0));
      do_reset();
      for (int c = 0; c < len; c++) begin
        if (c == rst_at) do_reset();
        else rand_cycle(free_pct);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frontend_fetch_decode_rename.md
Name: frontend_fetch_decode_rename

Overview:
In-order front end of the out-of-order RV32 core. It fetches 32-bit instructions from a flat instruction-ROM bus and decodes them into fields and control signals. It then renames architectural registers to 64 physical tags using a RAT, a free list and a physical register file with ready bits. Its outputs feed the reservation station.

Parameters:
ROM_WORDS, 256, number of 32-bit words on instr_rom.
PHYS_REGS, 64, physical registers (tag width 6).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
instr_rom  in  32*ROM_WORDS  word k = bits [32k+31:32k], little-endian already resolved
rom_size  in  32  program size in bytes
wakeup_active  in  1  writeback valid
wakeup_tag  in  6  physical tag being written
wakeup_value  in  32  result value
freed_tag_1, freed_tag_2  in  6 each  tags returned to free list; 0 = none
fetch_complete  out  1  pc >= rom_size
inst_valid  out  1  decoded instruction present this cycle
opcode  out  7;  rd, rs1, rs2  out  5 each;  func3  out  3;  imm  out  32
LoadStore, ALUSrc, RegWrite, BMS  out  1 each;  ALUControl  out  4
physical_rd, physical_rs1, physical_rs2  out  6 each
rs1_ready, rs2_ready  out  1 each;  rs1_value, rs2_value  out  32 each
rename_stall  out  1  free list empty and allocation needed

Behaviour:
Fetch:
- Internal 32-bit pc and instruction register ir.
- Each edge with reset high, !fetch_complete and !rename_stall: ir <= word[pc>>2], pc <= pc+4, inst_valid <= 1.
- With fetch_complete set: ir <= 0 and inst_valid <= 0.
- With rename_stall: pc, ir and inst_valid hold.
- fetch_complete is combinational: pc >= rom_size. rom_size=0 means complete immediately after reset.

Decode (combinational from ir):
- Field positions: opcode=ir[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20].
- imm by opcode:
  - I-type (0010011, 0000011): sign-extended ir[31:20].
  - S-type (0100011): sign-extended {ir[31:25], ir[11:7]}.
  - LUI (0110111): {ir[31:12], 12'b0}.
  - Otherwise 0.
- ALUControl: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 pass-imm (LUI).
  - R-type: chosen from func3 and ir[30].
  - I-ALU: same, with SUB not possible.
  - Load/store: ADD.
- RegWrite = 1 for R, I-ALU, load, LUI.
- ALUSrc = 1 for I-ALU, load, store, LUI.
- LoadStore = 1 for load or store.
- BMS = 1 for byte access (load/store with func3=000), else 0.
- Unknown opcode or ir=0: all controls 0, imm 0.

Rename:
- Reset state:
  - RAT[i] = i.
  - Physical regs 0..31 ready, value 0.
  - Free list FIFO holds tags 32..63 in ascending order.
- x0 always maps to tag 0, ready, value 0; never reallocated and never freed.
- Sources: physical_rsN = RAT[rsN]; ready and value come from the PRF.
  - Same-cycle bypass: if wakeup_active and wakeup_tag equals the source tag, ready=1 and value=wakeup_value.
- Destination (inst_valid && RegWrite && rd!=0): physical_rd = free-list head.
  - At the edge: pop head, RAT[rd] <= head, ready[head] <= 0.
  - Otherwise physical_rd = 0.
- Source lookup uses the RAT before this instruction's update, so rd==rs1 reads the old mapping.
- Wakeup at edge: ready[tag] <= 1, value[tag] <= value. Tag 0 is ignored.
- Frees at edge: push freed_tag_1 then freed_tag_2, if non-zero.
  - A push in the same cycle as a pop is allowed.
  - The free list never exceeds 63 entries.
- rename_stall = allocation needed && free list empty.
  - While stalled: no RAT change, outputs hold.
  - A tag freed this cycle becomes usable next cycle.
- Reset low at any time restores every reset state and sets pc=0, ir=0, inst_valid=0.

Test Plan:
- ROM word0=0x00700293 (ADDI x5,x0,7), rom_size=4: cycle 1 after reset → inst_valid=1, rd=5, imm=7, ALUSrc=1, RegWrite=1, ALUControl=0, physical_rd=32, physical_rs1=0, rs1_ready=1. Next cycle → fetch_complete=1, inst_valid=0.
- Follow with ADD x6,x5,x5 (0x00528333): physical_rs1=physical_rs2=32, rs1_ready=0, physical_rd=33. Wakeup tag 32 value 7 in the same cycle → rs1_ready=1, rs1_value=7.
- SB x5,3(x1) (0x005081A3): LoadStore=1, BMS=1, RegWrite=0, imm=3, physical_rd=0, no free-list pop.
- LUI x1,0x12345 (0x123450B7): imm=0x12345000, ALUControl=8. ADDI with imm field 0xFFF → imm=0xFFFFFFFF.
- 33 consecutive ADDIs writing x1, no frees: 33rd asserts rename_stall, pc holds. freed_tag_1=32 → next cycle the stall clears and physical_rd=32.
- Assert reset low mid-stream → pc=0, RAT identity, free-list head=32, all ready.
